fetch_queue: RTL and testbench

- Parametrised successor to the single-entry fetch stage. It issues sequential instruction-memory requests over a syn/ack handshake and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- It presents the FIFO head to decode, so memory latency is decoupled from downstream stalls.
- It supports branch redirect with in-flight discard, and a head-kill flush.

---
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Sequential instruction fetcher: one syn/ack request in flight, results buffered
// with their PCs in a DEPTH-entry FIFO whose head is presented to decode.
module fetch_queue #(
    parameter int                  IWIDTH   = 32,
    parameter int                  PC_WIDTH = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  PC_STEP  = 4
) (
    input  logic                fq_clk,
    input  logic                fq_rst,
    output logic                fq_o_syn,
    output logic [PC_WIDTH-1:0] fq_o_addr_instr,
    input  logic                fq_i_ack,
    input  logic [IWIDTH-1:0]   fq_i_instr,
    input  logic                fq_change_pc,
    input  logic [PC_WIDTH-1:0] fq_alu_pc_value,
    input  logic                fq_i_stall,
    input  logic                fq_i_flush,
    output logic [IWIDTH-1:0]   fq_o_instr_fetch,
    output logic [PC_WIDTH-1:0] fq_pc,
    output logic                fq_o_ce,
    output logic                fq_o_stall,
    output logic                fq_o_flush
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0]       FULL       = CW'(DEPTH);
    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(STEP - PC_WIDTH'(1));

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_t;

    state_t              state_reg, state_next;
    logic [PC_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PC_WIDTH-1:0] addr_reg, addr_next;
    logic [CW-1:0]       count_reg, count_next, count_after;
    logic [AW-1:0]       rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]       wr_ptr_reg, wr_ptr_next;
    logic                flush_reg;
    logic                pop, push;

    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
    logic [IWIDTH-1:0]   instr_mem [DEPTH];

    assign pop  = (count_reg != '0) && (!fq_i_stall || fq_i_flush);
    assign push = (state_reg == ST_WAIT) && fq_i_ack && !fq_change_pc;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        addr_next     = addr_reg;
        count_next    = count_reg;
        count_after   = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        if (fq_change_pc) begin
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            fetch_pc_next = fq_alu_pc_value & ALIGN_MASK;
            // The outstanding request must still complete on the bus; its data is dropped.
            case (state_reg)
                ST_WAIT: state_next = fq_i_ack ? ST_IDLE : ST_DROP;
                ST_DROP: state_next = fq_i_ack ? ST_IDLE : ST_DROP;
                default: state_next = ST_IDLE;
            endcase
        end else begin
            count_after = count_reg - CW'(pop) + CW'(push);
            count_next  = count_after;
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            if (push) begin
                wr_ptr_next   = wr_ptr_reg + AW'(1);
                fetch_pc_next = fetch_pc_reg + STEP;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (count_reg < FULL) begin
                        state_next = ST_WAIT;
                        addr_next  = fetch_pc_reg;
                    end
                end
                ST_WAIT: begin
                    if (fq_i_ack) begin
                        if (count_after < FULL) begin
                            addr_next = fetch_pc_reg + STEP;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (fq_i_ack) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge fq_clk) begin
        if (fq_rst) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= RESET_PC;
            addr_reg     <= RESET_PC;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            flush_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            addr_reg     <= addr_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            flush_reg    <= fq_change_pc | fq_i_flush;
        end
    end

    // Entry storage carries no reset; validity is tracked by count_reg alone.
    always_ff @(posedge fq_clk) begin
        if (push && !fq_rst) begin
            pc_mem[wr_ptr_reg]    <= addr_reg;
            instr_mem[wr_ptr_reg] <= fq_i_instr;
        end
    end

    assign fq_o_syn         = (state_reg != ST_IDLE);
    assign fq_o_addr_instr  = addr_reg;
    assign fq_o_ce          = (count_reg != '0);
    assign fq_o_stall       = (count_reg == '0);
    assign fq_o_flush       = flush_reg;
    assign fq_o_instr_fetch = fq_o_ce ? instr_mem[rd_ptr_reg] : '0;
    assign fq_pc            = fq_o_ce ? pc_mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic scored against
// a transaction-level queue model of the fetch stream.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        fq_clk = 1'b0;
    logic        fq_rst, fq_o_syn, fq_i_ack, fq_change_pc, fq_i_stall, fq_i_flush;
    logic        fq_o_ce, fq_o_stall, fq_o_flush;
    logic [31:0] fq_o_addr_instr, fq_i_instr, fq_alu_pc_value, fq_o_instr_fetch, fq_pc;

    logic        w_rst, w_syn, w_ack, w_ack_en, w_stray, w_ce, w_stall_o, w_flush_o;
    logic [31:0] w_addr, w_instr, w_instr_o, w_pc;

    always #5 fq_clk = ~fq_clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    fetch_queue #(.IWIDTH(32), .PC_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .fq_clk(fq_clk), .fq_rst(fq_rst), .fq_o_syn(fq_o_syn), .fq_o_addr_instr(fq_o_addr_instr),
        .fq_i_ack(fq_i_ack), .fq_i_instr(fq_i_instr), .fq_change_pc(fq_change_pc),
        .fq_alu_pc_value(fq_alu_pc_value), .fq_i_stall(fq_i_stall), .fq_i_flush(fq_i_flush),
        .fq_o_instr_fetch(fq_o_instr_fetch), .fq_pc(fq_pc), .fq_o_ce(fq_o_ce),
        .fq_o_stall(fq_o_stall), .fq_o_flush(fq_o_flush)
    );

    assign w_ack   = w_stray | (w_ack_en & w_syn);
    assign w_instr = mem_data(w_addr);

    fetch_queue #(.IWIDTH(32), .PC_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_w (
        .fq_clk(fq_clk), .fq_rst(w_rst), .fq_o_syn(w_syn), .fq_o_addr_instr(w_addr),
        .fq_i_ack(w_ack), .fq_i_instr(w_instr), .fq_change_pc(1'b0),
        .fq_alu_pc_value(32'h0), .fq_i_stall(1'b0), .fq_i_flush(1'b0),
        .fq_o_instr_fetch(w_instr_o), .fq_pc(w_pc), .fq_o_ce(w_ce),
        .fq_o_stall(w_stall_o), .fq_o_flush(w_flush_o)
    );

    // Model: FIFO contents, next sequential fetch address, the open bus request.
    entry_t      mq[$];
    logic [31:0] next_pc, req_addr;
    bit          req_open, stale, exp_flush, stray_en;
    int          lat_left, lat_mode;
    int          n_pass, n_checks;

    task automatic do_reset();
        @(negedge fq_clk);
        fq_rst = 1'b1; fq_i_ack = 1'b0; fq_change_pc = 1'b0; fq_i_stall = 1'b0;
        fq_i_flush = 1'b0; fq_alu_pc_value = '0; fq_i_instr = '0;
        repeat (2) @(negedge fq_clk);
        fq_rst = 1'b0;
        mq.delete();
        next_pc = 32'h0; req_open = 0; stale = 0; exp_flush = 0; lat_left = 0;
    endtask

    // One clock: score the visible outputs, play memory, drive inputs, advance the model.
    task automatic step(input logic stall, input logic flush, input logic chg, input logic [31:0] tgt);
        logic   ack_now, pop_now;
        entry_t e;
        @(negedge fq_clk);
        n_checks++;
        if (fq_o_ce !== (mq.size() != 0)) $display("FAIL ce: got %b want %b", fq_o_ce, mq.size() != 0);
        else n_pass++;
        n_checks++;
        if (fq_o_stall !== (mq.size() == 0)) $display("FAIL stall_out: got %b want %b", fq_o_stall, mq.size() == 0);
        else n_pass++;
        n_checks++;
        if (mq.size() != 0) begin
            if (fq_pc !== mq[0].pc || fq_o_instr_fetch !== mq[0].instr)
                $display("FAIL head: got pc %h instr %h want pc %h instr %h", fq_pc, fq_o_instr_fetch, mq[0].pc, mq[0].instr);
            else n_pass++;
        end else begin
            if (fq_pc !== 32'h0 || fq_o_instr_fetch !== 32'h0)
                $display("FAIL empty_data: got pc %h instr %h want 0 0", fq_pc, fq_o_instr_fetch);
            else n_pass++;
        end
        n_checks++;
        if (fq_o_flush !== exp_flush) $display("FAIL flush_pulse: got %b want %b", fq_o_flush, exp_flush);
        else n_pass++;
        n_checks++;
        if (fq_o_syn === 1'b1) begin
            if (!req_open) begin
                if (fq_o_addr_instr !== next_pc || mq.size() >= DEPTH)
                    $display("FAIL req_issue: got addr %h with %0d queued want addr %h with room", fq_o_addr_instr, mq.size(), next_pc);
                else n_pass++;
                req_open = 1;
                req_addr = fq_o_addr_instr;
                lat_left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end else begin
                if (fq_o_addr_instr !== req_addr) $display("FAIL req_hold: got addr %h want %h", fq_o_addr_instr, req_addr);
                else n_pass++;
            end
        end else begin
            if (fq_o_syn !== 1'b0 || req_open) $display("FAIL syn_drop: got syn %b want 1 (request open %0d)", fq_o_syn, req_open);
            else n_pass++;
        end

        ack_now = 1'b0;
        if (fq_o_syn === 1'b1) begin
            if (lat_left == 0) ack_now = 1'b1;
            else lat_left--;
        end
        fq_i_ack        = ack_now || (fq_o_syn !== 1'b1 && stray_en && $urandom_range(0, 3) == 0);
        fq_i_instr      = ack_now ? mem_data(req_addr) : $urandom;
        fq_i_stall      = stall;
        fq_i_flush      = flush;
        fq_change_pc    = chg;
        fq_alu_pc_value = tgt;

        pop_now = (mq.size() != 0) && (!stall || flush);
        if (chg) begin
            mq.delete();
            next_pc = tgt & 32'hFFFF_FFFC;
            stale   = req_open && !ack_now;
        end else begin
            if (pop_now) void'(mq.pop_front());
            if (ack_now) begin
                if (stale) begin
                    stale = 0;
                end else begin
                    e.pc = req_addr;
                    e.instr = mem_data(req_addr);
                    mq.push_back(e);
                    next_pc = req_addr + 32'd4;
                end
            end
        end
        if (ack_now) req_open = 0;
        exp_flush = chg | flush;
    endtask

    task automatic test_reset();
        do_reset();
        lat_mode = 2;
        repeat (3) step(0, 0, 0, 32'h0);
        do_reset();
        n_checks++;
        if (fq_o_syn !== 1'b0 || fq_o_flush !== 1'b0) $display("FAIL reset_ctl: got syn %b flush %b want 0 0", fq_o_syn, fq_o_flush);
        else n_pass++;
        n_checks++;
        if (fq_o_ce !== 1'b0 || fq_o_stall !== 1'b1) $display("FAIL reset_fifo: got ce %b stall %b want 0 1", fq_o_ce, fq_o_stall);
        else n_pass++;
        n_checks++;
        if (fq_pc !== 32'h0 || fq_o_instr_fetch !== 32'h0) $display("FAIL reset_data: got %h %h want 0 0", fq_pc, fq_o_instr_fetch);
        else n_pass++;
    endtask

    task automatic test_sequential();
        do_reset();
        lat_mode = 0;
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0, 32'h0);
            n_checks++;
            if (fq_o_syn !== 1'b1 || fq_o_addr_instr !== 32'((k - 1) * 4))
                $display("FAIL seq_addr: got syn %b addr %h want 1 %h", fq_o_syn, fq_o_addr_instr, 32'((k - 1) * 4));
            else n_pass++;
            n_checks++;
            if (k >= 2) begin
                if (fq_o_ce !== 1'b1 || fq_pc !== 32'((k - 2) * 4))
                    $display("FAIL seq_head: got ce %b pc %h want 1 %h", fq_o_ce, fq_pc, 32'((k - 2) * 4));
                else n_pass++;
            end else begin
                if (fq_o_ce !== 1'b0) $display("FAIL seq_first: got ce %b want 0", fq_o_ce);
                else n_pass++;
            end
        end
    endtask

    task automatic test_full_stall();
        int acks;
        bit found;
        logic [31:0] first;
        do_reset();
        lat_mode = 0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, 32'h0);
            if (fq_i_ack) acks++;
        end
        n_checks++;
        if (acks != DEPTH) $display("FAIL full_acks: got %0d want %0d", acks, DEPTH);
        else n_pass++;
        n_checks++;
        if (fq_o_syn !== 1'b0 || fq_o_ce !== 1'b1 || fq_pc !== 32'h0)
            $display("FAIL full_hold: got syn %b ce %b pc %h want 0 1 0", fq_o_syn, fq_o_ce, fq_pc);
        else n_pass++;
        found = 0;
        first = '0;
        for (int k = 0; k < 6 && !found; k++) begin
            step(0, 0, 0, 32'h0);
            if (fq_o_syn === 1'b1) begin found = 1; first = fq_o_addr_instr; end
        end
        n_checks++;
        if (!found || first !== 32'h10) $display("FAIL full_restart: got found %0d addr %h want 1 00000010", found, first);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        int flushes;
        bit found;
        logic [31:0] first;
        do_reset();
        lat_mode = 3;
        step(0, 0, 1, 32'h103);
        n_checks++;
        if (fq_o_syn !== 1'b1) $display("FAIL rw_first: got syn %b want 1", fq_o_syn);
        else n_pass++;
        flushes = 0;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 32'h0);
            if (fq_o_flush === 1'b1) flushes++;
            n_checks++;
            if (fq_o_syn !== 1'b1 || fq_o_addr_instr !== 32'h0)
                $display("FAIL rw_hold: got syn %b addr %h want 1 0", fq_o_syn, fq_o_addr_instr);
            else n_pass++;
        end
        found = 0;
        first = '0;
        for (int k = 0; k < 6 && !found; k++) begin
            step(0, 0, 0, 32'h0);
            if (fq_o_flush === 1'b1) flushes++;
            n_checks++;
            if (fq_o_ce !== 1'b0) $display("FAIL rw_empty: got ce %b want 0", fq_o_ce);
            else n_pass++;
            if (fq_o_syn === 1'b1) begin found = 1; first = fq_o_addr_instr; end
        end
        n_checks++;
        if (!found || first !== 32'h100) $display("FAIL rw_target: got found %0d addr %h want 1 00000100", found, first);
        else n_pass++;
        n_checks++;
        if (flushes != 1) $display("FAIL rw_pulses: got %0d want 1", flushes);
        else n_pass++;
    endtask

    task automatic test_redirect_ack();
        bit found;
        logic [31:0] first;
        do_reset();
        lat_mode = 0;
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        step(1, 0, 1, 32'h200);
        n_checks++;
        if (fq_o_syn !== 1'b1 || fq_o_addr_instr !== 32'h8 || fq_pc !== 32'h0)
            $display("FAIL ra_setup: got syn %b addr %h head %h want 1 8 0", fq_o_syn, fq_o_addr_instr, fq_pc);
        else n_pass++;
        step(0, 0, 0, 32'h0);
        n_checks++;
        if (fq_o_ce !== 1'b0 || fq_o_flush !== 1'b1 || fq_o_syn !== 1'b0)
            $display("FAIL ra_after: got ce %b flush %b syn %b want 0 1 0", fq_o_ce, fq_o_flush, fq_o_syn);
        else n_pass++;
        found = 0;
        first = '0;
        for (int k = 0; k < 4 && !found; k++) begin
            step(0, 0, 0, 32'h0);
            if (fq_o_syn === 1'b1) begin found = 1; first = fq_o_addr_instr; end
        end
        n_checks++;
        if (!found || first !== 32'h200) $display("FAIL ra_target: got found %0d addr %h want 1 00000200", found, first);
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        lat_mode = 0;
        repeat (4) step(1, 0, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        n_checks++;
        if (fq_pc !== 32'h8) $display("FAIL fl_before: got pc %h want 00000008", fq_pc);
        else n_pass++;
        step(1, 0, 0, 32'h0);
        n_checks++;
        if (fq_pc !== 32'hC || fq_o_flush !== 1'b1) $display("FAIL fl_after: got pc %h flush %b want 0000000c 1", fq_pc, fq_o_flush);
        else n_pass++;
        do_reset();
        lat_mode = 3;
        step(0, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        n_checks++;
        if (fq_o_ce !== 1'b0 || fq_o_flush !== 1'b1 || fq_o_syn !== 1'b1 || fq_o_addr_instr !== 32'h0)
            $display("FAIL fl_empty: got ce %b flush %b syn %b addr %h want 0 1 1 0", fq_o_ce, fq_o_flush, fq_o_syn, fq_o_addr_instr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4];
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
        @(negedge fq_clk);
        w_ack_en = 1'b0; w_stray = 1'b0; w_rst = 1'b1;
        repeat (2) @(negedge fq_clk);
        w_rst = 1'b0; w_ack_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge fq_clk);
            n_checks++;
            if (w_syn !== 1'b1 || w_addr !== exp_a[k]) $display("FAIL wrap_addr: got syn %b addr %h want 1 %h", w_syn, w_addr, exp_a[k]);
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if (w_pc !== exp_a[k-1] || w_instr_o !== mem_data(exp_a[k-1]))
                    $display("FAIL wrap_head: got pc %h instr %h want %h %h", w_pc, w_instr_o, exp_a[k-1], mem_data(exp_a[k-1]));
                else n_pass++;
            end
        end
        w_ack_en = 1'b0; w_rst = 1'b1;
        @(negedge fq_clk);
        w_rst = 1'b0; w_stray = 1'b1;
        n_checks++;
        if (w_syn !== 1'b0 || w_ce !== 1'b0 || w_stall_o !== 1'b1) $display("FAIL wrap_rst: got syn %b ce %b stall %b want 0 0 1", w_syn, w_ce, w_stall_o);
        else n_pass++;
        @(negedge fq_clk);
        w_stray = 1'b0;
        n_checks++;
        if (w_ce !== 1'b0 || w_syn !== 1'b1 || w_addr !== 32'hFFFF_FFF8 || w_flush_o !== 1'b0)
            $display("FAIL wrap_stray: got ce %b syn %b addr %h flush %b want 0 1 fffffff8 0", w_ce, w_syn, w_addr, w_flush_o);
        else n_pass++;
    endtask

    task automatic test_random();
        logic stall, flush, chg;
        do_reset();
        lat_mode = -1;
        stray_en = 1;
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            chg   = ($urandom_range(0, 99) < 3);
            stall = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 19) == 0);
            step(stall, flush, chg, $urandom);
        end
        stray_en = 0;
    endtask

    initial begin
        n_pass = 0; n_checks = 0; lat_mode = 0; stray_en = 0;
        fq_rst = 1'b1; fq_i_ack = 1'b0; fq_i_instr = '0; fq_change_pc = 1'b0;
        fq_alu_pc_value = '0; fq_i_stall = 1'b0; fq_i_flush = 1'b0;
        w_rst = 1'b1; w_ack_en = 1'b0; w_stray = 1'b0;
        test_reset();
        test_sequential();
        test_full_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_flush();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
